// File: rtl/alu_cmd_issue_if.sv
// Command, ALU-drive and result bundle for alu_cmd_issue.
// slave is the issue block's view; master is the producer/ALU/consumer side.
// fifo_count width follows AW (count is AW+1 bits).
interface alu_cmd_issue_if #(
  parameter int AW = 2
);
  logic          flush;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [2:0]    cmd_sel;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [3:0]    alu_result;
  logic          alu_carry;
  logic          res_valid;
  logic          res_ready;
  logic [3:0]    res_data;
  logic          res_carry;
  logic          res_zero;
  logic [2:0]    res_sel;
  logic [AW:0]   fifo_count;

  modport slave (
    input  flush, cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, alu_carry, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_zero,
           res_sel, fifo_count
  );

  modport master (
    output flush, cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, alu_carry, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_zero,
           res_sel, fifo_count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Purpose: buffer {A,B,sel} commands, drive registered operands into the ALU, capture result+flags.
// Latency: push at edge N -> alu_* valid after N+1 -> res_valid after N+2; one command/cycle.
// Backpressure: res_ready=0 fills result reg, issue reg, then DEPTH FIFO slots; cmd_ready then drops.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_cmd_issue_if.slave bus
);

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  cmd_t          head;

  logic          iss_v;
  logic [3:0]    iss_a;
  logic [3:0]    iss_b;
  logic [2:0]    iss_sel;

  logic          res_v;
  logic [3:0]    res_d;
  logic          res_c;
  logic          res_z;
  logic [2:0]    res_s;

  logic          push;
  logic          pop;
  logic          res_adv;

  // Handshake decisions: the result stage frees up when empty or being drained this cycle,
  // and the issue stage refills from the FIFO whenever it is empty or moving forward.
  assign bus.cmd_ready = (count < FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign res_adv       = iss_v && (!res_v || bus.res_ready);
  assign pop           = (count != '0) && (!iss_v || res_adv);
  assign head          = mem[rd_ptr];

  // FIFO storage: data only, no reset needed; stale entries are never read because count gates pop.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  // FIFO pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue stage: operand registers feeding the ALU; held while the result stage is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v   <= 1'b0;
      iss_a   <= '0;
      iss_b   <= '0;
      iss_sel <= '0;
    end else if (bus.flush) begin
      iss_v   <= 1'b0;
    end else if (pop) begin
      iss_v   <= 1'b1;
      iss_a   <= head.a;
      iss_b   <= head.b;
      iss_sel <= head.sel;
    end else if (res_adv) begin
      iss_v   <= 1'b0;
    end
  end

  // Result stage: capture the ALU outputs plus a zero flag and the opcode tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_v <= 1'b0;
      res_d <= '0;
      res_c <= 1'b0;
      res_z <= 1'b0;
      res_s <= '0;
    end else if (bus.flush) begin
      res_v <= 1'b0;
    end else if (res_adv) begin
      res_v <= 1'b1;
      res_d <= bus.alu_result;
      res_c <= bus.alu_carry;
      res_z <= (bus.alu_result == 4'b0000);
      res_s <= iss_sel;
    end else if (bus.res_ready) begin
      res_v <= 1'b0;
    end
  end

  assign bus.alu_a      = iss_a;
  assign bus.alu_b      = iss_b;
  assign bus.alu_sel    = iss_sel;
  assign bus.res_valid  = res_v;
  assign bus.res_data   = res_d;
  assign bus.res_carry  = res_c;
  assign bus.res_zero   = res_z;
  assign bus.res_sel    = res_s;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: models the 4-bit ALU combinationally, checks directed vectors,
// burst/backpressure, flush and async reset sequences, then 1000 random commands.
module tb_alu_cmd_issue;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alu_cmd_issue_if #(.AW(2)) bus();

  alu_cmd_issue #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ALU behaviour: bit 4 is carry (ADD/INC) or borrow (SUB/DEC), 0 for logic ops.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a} + 5'd1;
      default: return {1'b0, a} - 5'd1;
    endcase
  endfunction

  // Expected result record {data, carry, zero, sel} for a command.
  function automatic logic [8:0] expect_of(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
    logic [4:0] r;
    r = alu_f(a, b, s);
    return {r[3:0], r[4], (r[3:0] == 4'd0), s};
  endfunction

  assign {bus.alu_carry, bus.alu_result} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb_q[$];
  logic       last_push;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] exp_d;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample handshakes just before the rising edge, update the scoreboard,
  // then return on the following falling edge where stimulus may change.
  task automatic cyc();
    logic [8:0] exp_v;
    #4;
    last_push = bus.cmd_valid && bus.cmd_ready && !bus.flush;
    if (bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: result %0h delivered, none expected", bus.res_data);
      end else begin
        exp_v = sb_q.pop_front();
        chk("sb_result", 32'({bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel}),
            32'(exp_v));
      end
    end
    if (bus.flush) sb_q.delete();
    else if (last_push) sb_q.push_back(expect_of(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (last_push) break;
    end
    if (!last_push) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: command not accepted within 50 cycles");
    end
  endtask

  task automatic drain(input int budget);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && !bus.res_valid) break;
      cyc();
    end
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int ncyc;
    logic pend;

    tv[0] = '{4'd9,  4'd8, 3'd0, 4'h1, 1'b1, 1'b0};  // ADD 9+8
    tv[1] = '{4'd3,  4'd3, 3'd1, 4'h0, 1'b0, 1'b1};  // SUB 3-3
    tv[2] = '{4'd0,  4'd0, 3'd7, 4'hF, 1'b1, 1'b0};  // DEC 0
    tv[3] = '{4'hC,  4'hA, 3'd2, 4'h8, 1'b0, 1'b0};  // AND
    tv[4] = '{4'h5,  4'hA, 3'd3, 4'hF, 1'b0, 1'b0};  // OR
    tv[5] = '{4'hF,  4'hF, 3'd4, 4'h0, 1'b0, 1'b1};  // XOR
    tv[6] = '{4'h5,  4'h0, 3'd5, 4'hA, 1'b0, 1'b0};  // NOT
    tv[7] = '{4'hF,  4'h0, 3'd6, 4'h0, 1'b1, 1'b1};  // INC F
    tv[8] = '{4'd2,  4'd5, 3'd1, 4'hD, 1'b1, 1'b0};  // SUB 2-5

    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;
    last_push     = 1'b0;

    // Power-on reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_count",     32'(bus.fifo_count), 32'd0);
    chk("rst_alu",       32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'd0);
    chk("rst_res",       32'({bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Directed vectors: single command into an idle block, latency and flags
    bus.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.cmd_a     = tv[i].a;
      bus.cmd_b     = tv[i].b;
      bus.cmd_sel   = tv[i].sel;
      bus.cmd_valid = 1'b1;
      cyc();
      bus.cmd_valid = 1'b0;
      chk("tv_accept", 32'(last_push), 32'd1);
      chk("tv_count_n", 32'(bus.fifo_count), 32'd1);
      chk("tv_res_n", 32'(bus.res_valid), 32'd0);
      cyc();
      chk("tv_alu_n1", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}),
          32'({tv[i].a, tv[i].b, tv[i].sel}));
      chk("tv_res_n1", 32'(bus.res_valid), 32'd0);
      cyc();
      chk("tv_res_n2", 32'(bus.res_valid), 32'd1);
      chk("tv_data", 32'({bus.res_data, bus.res_carry, bus.res_zero, bus.res_sel}),
          32'({tv[i].exp_d, tv[i].exp_c, tv[i].exp_z, tv[i].sel}));
      cyc();
      chk("tv_consumed", 32'(bus.res_valid), 32'd0);
    end

    // Burst of 6 with consumer stalled: result + issue + 4 FIFO entries
    bus.res_ready = 1'b0;
    push_cmd(4'd9, 4'd8, 3'd0);
    push_cmd(4'd3, 4'd3, 3'd1);
    push_cmd(4'd0, 4'd0, 3'd7);
    push_cmd(4'd6, 4'd3, 3'd4);
    push_cmd(4'd7, 4'd0, 3'd6);
    push_cmd(4'hF, 4'd5, 3'd2);
    chk("burst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("burst_count", 32'(bus.fifo_count), 32'd4);
    chk("burst_head", 32'({bus.res_valid, bus.res_data, bus.res_carry}), 32'({1'b1, 4'h1, 1'b1}));
    bus.cmd_a   = 4'd1;
    bus.cmd_b   = 4'd1;
    bus.cmd_sel = 3'd0;
    cyc();
    chk("full_no_push", 32'(last_push), 32'd0);
    chk("full_count", 32'(bus.fifo_count), 32'd4);

    // Full FIFO, consumer and producer active together
    bus.res_ready = 1'b1;
    cyc();
    chk("fullrel_no_push", 32'(last_push), 32'd0);
    chk("fullrel_count", 32'(bus.fifo_count), 32'd3);
    cyc();
    chk("fullrel_push", 32'(last_push), 32'd1);
    chk("fullrel_count2", 32'(bus.fifo_count), 32'd3);
    push_cmd(4'd5, 4'd2, 3'd1);
    chk("fullrel_count3", 32'(bus.fifo_count), 32'd3);
    drain(40);

    // Flush with 3 queued and a result waiting; same-cycle push is dropped
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(i + 1), 4'd2, 3'd0);
    chk("pre_flush_count", 32'(bus.fifo_count), 32'd3);
    chk("pre_flush_res", 32'(bus.res_valid), 32'd1);
    bus.cmd_a   = 4'd4;
    bus.cmd_b   = 4'd4;
    bus.cmd_sel = 3'd3;
    bus.flush   = 1'b1;
    cyc();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("flush_res", 32'(bus.res_valid), 32'd0);
    chk("flush_count", 32'(bus.fifo_count), 32'd0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("flush_quiet", 32'({bus.res_valid, bus.fifo_count}), 32'd0);
    push_cmd(4'd2, 4'd2, 3'd0);
    drain(20);

    // Asynchronous reset in the middle of traffic
    bus.res_ready = 1'b0;
    push_cmd(4'd5, 4'd9, 3'd3);
    push_cmd(4'd6, 4'd1, 3'd0);
    push_cmd(4'd7, 4'd2, 3'd1);
    bus.cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'd0);
    chk("arst_res_data", 32'(bus.res_data), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Random valid/ready traffic, 1000 commands
    sent = 0;
    ncyc = 0;
    pend = 1'b0;
    while (sent < 1000 && ncyc < 20000) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        bus.cmd_a   = 4'($urandom_range(0, 15));
        bus.cmd_b   = 4'($urandom_range(0, 15));
        bus.cmd_sel = 3'($urandom_range(0, 7));
        pend        = 1'b1;
      end
      bus.cmd_valid = pend;
      bus.res_ready = ($urandom_range(0, 9) < 6);
      cyc();
      ncyc++;
      if (last_push) begin
        pend = 1'b0;
        sent++;
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
